// File: rtl/esfa_pkg.sv
// Shared types for the free-cell allocator path: handle width, handle type and selector FSM states.
package esfa_pkg;

    localparam int HANDLE_W = 8;

    typedef logic [HANDLE_W-1:0] handle_t;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        RESULT
    } sel_state_t;

endpackage

// File: rtl/available_cell_selector_if.sv
// Request/result bundle between the cell array mark stage, the selector and its consumer.
interface available_cell_selector_if #(
    parameter int NUM_CELLS = 16,
    parameter int HANDLE_W  = esfa_pkg::HANDLE_W
);
    localparam int IDX_W = $clog2(NUM_CELLS);

    logic                          start;
    logic [NUM_CELLS-1:0]          mark_free;
    logic [NUM_CELLS*HANDLE_W-1:0] mark_handle;
    logic                          busy;
    logic                          res_valid;
    logic                          res_ready;
    logic                          res_found;
    logic [HANDLE_W-1:0]           res_handle;
    logic [IDX_W-1:0]              res_index;

    modport master (
        output start, mark_free, mark_handle, res_ready,
        input  busy, res_valid, res_found, res_handle, res_index
    );

    modport slave (
        input  start, mark_free, mark_handle, res_ready,
        output busy, res_valid, res_found, res_handle, res_index
    );

endinterface

// File: rtl/available_cell_selector_lane_first_set.sv
// Combinational LANES-wide priority encoder: reports whether any lane is set and the lowest set lane.
module lane_first_set #(
    parameter int LANES = 4,
    parameter int OFF_W = (LANES > 1) ? $clog2(LANES) : 1
) (
    input  logic [LANES-1:0] bits,
    output logic             any,
    output logic [OFF_W-1:0] off
);

    always_comb begin
        any = |bits;
        off = '0;
        // Walk downwards so the lowest set lane is the one left standing.
        for (int i = LANES - 1; i >= 0; i--) begin
            if (bits[i]) off = OFF_W'(i);
        end
    end

endmodule

// File: rtl/available_cell_selector.sv
// Lowest-index free cell search over a snapshot of the mark results, LANES cells per cycle.
// Optional next-fit start position enabled by defining ESFA_NEXT_FIT_EN.
module available_cell_selector #(
    parameter int NUM_CELLS = 16,
    parameter int LANES     = 4,
    parameter int HANDLE_W  = esfa_pkg::HANDLE_W
) (
    input  logic                       clk,
    input  logic                       rst_n,
    available_cell_selector_if.slave   bus
);
    import esfa_pkg::*;

    localparam int IDX_W   = $clog2(NUM_CELLS);
    localparam int LW      = $clog2(LANES);
    localparam int OFF_W   = (LANES > 1) ? LW : 1;
    localparam int NGROUPS = NUM_CELLS / LANES;
    localparam int GW      = (IDX_W > LW) ? IDX_W - LW : 1;
    localparam int CW      = $clog2(NGROUPS + 2);

    sel_state_t                    state;
    logic                          busy_r;
    logic                          valid_r;
    logic                          found_r;
    logic [HANDLE_W-1:0]           handle_r;
    logic [IDX_W-1:0]              index_r;

    logic [NUM_CELLS-1:0]          snap_free;
    logic [NUM_CELLS*HANDLE_W-1:0] snap_handle;
    logic [GW-1:0]                 grp;
    logic [CW-1:0]                 fetch_cnt;
    logic                          fetch_done;
    logic                          is_last_fetch;

    logic [LANES-1:0]              grp_slice;
    logic [LANES-1:0]              lane_mask;
    logic [LANES-1:0]              grp_bits_p0;
    logic [IDX_W-1:0]              base_idx_p0;
    logic                          last_p0;
    logic                          vld_p0;

    logic                          enc_any;
    logic [OFF_W-1:0]              enc_off;
    logic [IDX_W-1:0]              hit_idx;
    logic [HANDLE_W-1:0]           hit_handle;

`ifdef ESFA_NEXT_FIT_EN
    logic [IDX_W-1:0]              next_ptr;
    logic [OFF_W-1:0]              start_off;

    function automatic logic [LANES-1:0] hi_mask(input logic [OFF_W-1:0] o);
        hi_mask = {LANES{1'b1}} << o;
    endfunction
`endif

    assign bus.busy       = busy_r;
    assign bus.res_valid  = valid_r;
    assign bus.res_found  = found_r;
    assign bus.res_handle = handle_r;
    assign bus.res_index  = index_r;

    always_comb begin
        grp_slice = snap_free[int'(grp) * LANES +: LANES];
        lane_mask = '1;
`ifdef ESFA_NEXT_FIT_EN
        // First pass skips cells below the start position; the extra final step revisits only them.
        if (fetch_cnt == '0) begin
            lane_mask = hi_mask(start_off);
        end else if (int'(fetch_cnt) == NGROUPS) begin
            lane_mask = ~hi_mask(start_off);
        end
        is_last_fetch = (int'(fetch_cnt) == ((start_off == '0) ? NGROUPS - 1 : NGROUPS));
`else
        is_last_fetch = (int'(fetch_cnt) == NGROUPS - 1);
`endif
    end

    lane_first_set #(
        .LANES (LANES),
        .OFF_W (OFF_W)
    ) u_lane_first_set (
        .bits (grp_bits_p0),
        .any  (enc_any),
        .off  (enc_off)
    );

    assign hit_idx    = base_idx_p0 + IDX_W'(enc_off);
    assign hit_handle = snap_handle[int'(hit_idx) * HANDLE_W +: HANDLE_W];

    // Stage p0: snapshot capture and masked group fetch
    always_ff @(posedge clk) begin
        if (state == IDLE && bus.start) begin
            snap_free   <= bus.mark_free;
            snap_handle <= bus.mark_handle;
        end
        if (state == SCAN && !fetch_done) begin
            grp_bits_p0 <= grp_slice & lane_mask;
            base_idx_p0 <= IDX_W'(int'(grp) * LANES);
            last_p0     <= is_last_fetch;
        end
    end

    // Stage p1: encode fetched group, FSM and result registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            busy_r     <= 1'b0;
            valid_r    <= 1'b0;
            found_r    <= 1'b0;
            handle_r   <= '0;
            index_r    <= '0;
            grp        <= '0;
            fetch_cnt  <= '0;
            fetch_done <= 1'b0;
            vld_p0     <= 1'b0;
`ifdef ESFA_NEXT_FIT_EN
            next_ptr   <= '0;
            start_off  <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        state      <= SCAN;
                        busy_r     <= 1'b1;
                        fetch_cnt  <= '0;
                        fetch_done <= 1'b0;
                        vld_p0     <= 1'b0;
`ifdef ESFA_NEXT_FIT_EN
                        grp        <= GW'(next_ptr >> LW);
                        start_off  <= OFF_W'(int'(next_ptr) & (LANES - 1));
`else
                        grp        <= '0;
`endif
                    end
                end

                SCAN: begin
                    if (!fetch_done) begin
                        grp        <= (int'(grp) == NGROUPS - 1) ? '0 : grp + 1'b1;
                        fetch_cnt  <= fetch_cnt + 1'b1;
                        fetch_done <= is_last_fetch;
                    end
                    vld_p0 <= !fetch_done;
                    if (vld_p0) begin
                        if (enc_any) begin
                            state      <= RESULT;
                            valid_r    <= 1'b1;
                            found_r    <= 1'b1;
                            handle_r   <= hit_handle;
                            index_r    <= hit_idx;
                            vld_p0     <= 1'b0;
                            fetch_done <= 1'b1;
                        end else if (last_p0) begin
                            state    <= RESULT;
                            valid_r  <= 1'b1;
                            found_r  <= 1'b0;
                            handle_r <= '0;
                            index_r  <= '0;
                            vld_p0   <= 1'b0;
                        end
                    end
                end

                RESULT: begin
                    if (valid_r && bus.res_ready) begin
                        state   <= IDLE;
                        busy_r  <= 1'b0;
                        valid_r <= 1'b0;
`ifdef ESFA_NEXT_FIT_EN
                        if (found_r) begin
                            next_ptr <= (int'(index_r) == NUM_CELLS - 1) ? '0 : index_r + 1'b1;
                        end
`endif
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule
